extrema_scanner: RTL and testbench
==================================

# extrema_scanner

Parametrised scale-space extrema detector for the SIFT DoG stage. It scans `NUM_DOG` same-size DoG images held in parallel BRAMs, which share one read address. Each interior pixel of every scale is compared against its 3×3×3 neighbourhood, clipped to the scales that exist. Keypoints stream out over a valid/ready handshake toward the descriptor stage.

## Interface
- `BIT_DEPTH`, 9: signed DoG sample width.
- `DIMENSION`, 64: image side length in pixels (square image); must be ≥ 3.
- `NUM_DOG`, 2: number of DoG images per octave; must be ≥ 2.
- `READ_LATENCY`, 2: BRAM address-to-data latency in cycles; must be ≥ 1.
- `ABS_CONTRAST_THRESHOLD`, 4: minimum |sample| for a keypoint. Only used when the contrast macro is enabled.
- `clk`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a scan. Ignored while `busy`.
- `dog_address`  out  $clog2(DIMENSION*DIMENSION)  shared read address for all DoG BRAMs.
- `dog_data`  in  NUM_DOG*BIT_DEPTH  read data. Scale s occupies bits [s*BIT_DEPTH +: BIT_DEPTH] and is signed.
- `kp_valid`  out  1  keypoint available.
- `kp_ready`  in  1  downstream accepts the keypoint.
- `kp_x`, `kp_y`  out  $clog2(DIMENSION) each  keypoint coordinates.
- `kp_scale`  out  $clog2(NUM_DOG) (minimum width 1)  DoG index of the keypoint.
- `kp_is_max`  out  1  1 = maximum, 0 = minimum.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` is asserted.
- `done`  out  1  one-cycle pulse when the scan is complete.

## Operation
- Scan order is raster: y = 1..DIMENSION-2 (outer), x = 1..DIMENSION-2 (inner). Address = y*DIMENSION + x.
- The block holds a 3×3 window register per scale.
- States: IDLE → FILL → COMPARE → EMIT → ADVANCE → (SHIFT | FILL | FINISH) → IDLE.
- FILL (start of each row): issues 9 addresses, one per cycle, covering columns x-1..x+1 for rows y-1..y+1. The returning data is captured READ_LATENCY cycles after each address is issued.
- SHIFT (next x in the same row): the window moves left by one column. Then 3 addresses are issued for column x+1, rows y-1..y+1.
- COMPARE (one cycle) evaluates every scale s in parallel, treating samples as signed:
  - The centre c is a maximum if c is strictly greater than all 8 in-plane neighbours and all 9 window samples of scale s-1 and scale s+1, where those scales exist.
  - A minimum is defined the same way with "strictly less".
  - Any tie disqualifies the pixel.
  - Scales 0 and NUM_DOG-1 compare against their single adjacent scale only.
  - The results are latched as a per-scale flag vector.
- EMIT: presents the flagged scales one at a time in ascending s.
  - Each keypoint is held until the handshake completes (`kp_valid && kp_ready`).
  - The flag for that scale is then cleared.
  - Once no flags remain, the block moves to ADVANCE; with no flags set, EMIT takes 0 cycles.
- ADVANCE:
  - x < DIMENSION-2: x+1, go to SHIFT.
  - Otherwise, if y < DIMENSION-2: x = 1, y+1, go to FILL.
  - Otherwise go to FINISH, which pulses `done` and returns to IDLE.
- Reset values: every output is 0 and the state is IDLE.
- Reset mid-scan aborts the scan immediately. No `done` is produced.

## Timing
- `dog_address` is registered and changes only while issuing reads in FILL or SHIFT.
- FILL takes 9 + READ_LATENCY cycles; SHIFT takes 1 + 3 + READ_LATENCY cycles (window shift plus reads); COMPARE takes 1 cycle; ADVANCE takes 1 cycle.
- `kp_*` fields are stable while `kp_valid` is high. `kp_valid` never drops without a completed handshake.
- A `start` pulse in the same cycle as `done` is ignored. A new scan needs a `start` pulse after the block has returned to IDLE.
- DIMENSION = 3 gives exactly one pixel, (1,1).

## Configuration
- `EXTREMA_CONTRAST_EN` defined: a scale is flagged only if, in addition to passing the extremum test, |c| > ABS_CONTRAST_THRESHOLD (strictly greater). |c| is computed at BIT_DEPTH+1 bits.
- Not defined: no contrast check; every strict extremum is reported.

## Test plan
- Scan with DIMENSION=4, NUM_DOG=2, all samples 0 except scale0 (1,1) = 20:
  - One keypoint: x=1, y=1, scale=0, is_max=1.
  - `done` pulses exactly once.
- Same setup with scale1 (1,1) = 20 as well:
  - The tie disqualifies both pixels; zero keypoints.
  - `done` still pulses.
- NUM_DOG=3, scale1 (2,2) = -30 in a field of 0:
  - One keypoint: scale=1, is_max=0.
- Macro enabled, threshold 4, isolated peak of 3:
  - No keypoint.
  - Without the macro the same stimulus gives one keypoint.
- `kp_ready` held low for 10 cycles while two scales are flagged at the same pixel:
  - `kp_valid` stays high with fields stable.
  - On release the scales are emitted in order 0 then 1.
- `rst_in` asserted low during FILL of row 2:
  - All outputs read 0 on the next clock edge; no `done`.
  - After reset is released, a fresh `start` rescans from (1,1).

Source files
------------

// File: rtl/extrema_scanner_if.sv
// extrema_scanner_if
//   Bundles the DoG BRAM read bus and the keypoint valid/ready stream of the
//   extrema scanner.
//   master : scanner side  (drives dog_address and kp_*, reads dog_data/kp_ready)
//   slave  : memory/consumer side (drives dog_data and kp_ready)
// Signals:
//   dog_address  shared read address for all DoG BRAMs
//   dog_data     NUM_DOG samples, scale s at [s*BIT_DEPTH +: BIT_DEPTH], signed
//   kp_valid/kp_ready  keypoint handshake
//   kp_x, kp_y, kp_scale, kp_is_max  keypoint fields
interface extrema_scanner_if #(
  parameter int BIT_DEPTH = 9,
  parameter int DIMENSION = 64,
  parameter int NUM_DOG   = 2
);
  localparam int ADDR_W  = $clog2(DIMENSION * DIMENSION);
  localparam int COORD_W = $clog2(DIMENSION);
  localparam int SCALE_W = (NUM_DOG > 2) ? $clog2(NUM_DOG) : 1;

  logic [ADDR_W-1:0]            dog_address;
  logic [NUM_DOG*BIT_DEPTH-1:0] dog_data;
  logic                         kp_valid;
  logic                         kp_ready;
  logic [COORD_W-1:0]           kp_x;
  logic [COORD_W-1:0]           kp_y;
  logic [SCALE_W-1:0]           kp_scale;
  logic                         kp_is_max;

  modport master (
    output dog_address,
    input  dog_data,
    output kp_valid,
    input  kp_ready,
    output kp_x,
    output kp_y,
    output kp_scale,
    output kp_is_max
  );

  modport slave (
    input  dog_address,
    output dog_data,
    input  kp_valid,
    output kp_ready,
    input  kp_x,
    input  kp_y,
    input  kp_scale,
    input  kp_is_max
  );
endinterface

// File: rtl/extrema_scanner.sv
// extrema_scanner
//   Scale-space extrema detector for the SIFT DoG stage. Scans NUM_DOG
//   same-size DoG images (parallel BRAMs sharing one read address) in raster
//   order over the interior pixels, compares every centre sample against its
//   3x3x3 neighbourhood (clipped to existing scales) and streams keypoints out.
// Ports:
//   clk     system clock
//   rst_in  asynchronous active-low reset
//   start   one-cycle pulse that begins a scan (ignored unless idle)
//   busy    high while a scan is in progress
//   done    one-cycle pulse at the end of a scan
//   bus     extrema_scanner_if.master: BRAM read bus + keypoint stream
// Build option:
//   EXTREMA_CONTRAST_EN  when defined, a keypoint also needs
//                        |centre| > ABS_CONTRAST_THRESHOLD.
// READ_LATENCY counts from the cycle in which the address register is loaded
// to the cycle in which the matching data is captured.
module extrema_scanner #(
  parameter int BIT_DEPTH              = 9,
  parameter int DIMENSION              = 64,
  parameter int NUM_DOG                = 2,
  parameter int READ_LATENCY           = 2,
  parameter int ABS_CONTRAST_THRESHOLD = 4
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  extrema_scanner_if.master bus
);
  localparam int ADDR_W  = $clog2(DIMENSION * DIMENSION);
  localparam int COORD_W = $clog2(DIMENSION);
  localparam int SCALE_W = (NUM_DOG > 2) ? $clog2(NUM_DOG) : 1;
  localparam int CNT_W   = $clog2(READ_LATENCY + 10);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_ADVANCE = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  // Window slot k = row*3 + col, slot 4 is the centre.
  typedef logic [8:0][BIT_DEPTH-1:0] win_t;

  logic [2:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [COORD_W-1:0] x_reg, y_reg;
  win_t               win_reg [NUM_DOG];
  logic [NUM_DOG-1:0] flags_reg, max_reg;
  logic [ADDR_W-1:0]  dog_address_reg;
  logic               kp_valid_reg, kp_is_max_reg;
  logic [COORD_W-1:0] kp_x_reg, kp_y_reg;
  logic [SCALE_W-1:0] kp_scale_reg;
  logic               busy_reg, done_reg;

  logic [ADDR_W-1:0]  fill_addr, shift_addr;
  logic               cap_en;
  logic [3:0]         cap_slot;
  logic [NUM_DOG-1:0] cand_max, cand_min, cand_any;
  logic [NUM_DOG-1:0] pending, pick_src, max_src;
  logic [SCALE_W-1:0] pick_idx;
  logic               pick_max;

  // Returns {centre > every sample, centre < every sample}; the centre slot
  // is skipped for the scale's own plane.
  function automatic logic [1:0] plane_cmp(input logic signed [BIT_DEPTH-1:0] ctr,
                                           input win_t plane, input logic skip_ctr);
    logic all_gt, all_lt;
    all_gt = 1'b1;
    all_lt = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (!(skip_ctr && k == 4)) begin
        if (!(ctr > $signed(plane[k]))) all_gt = 1'b0;
        if (!(ctr < $signed(plane[k]))) all_lt = 1'b0;
      end
    end
    return {all_gt, all_lt};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOG; gi++) begin : g_scale
      logic signed [BIT_DEPTH-1:0] ctr;
      logic [1:0] own_cmp, lo_cmp, hi_cmp;
      logic       contrast_ok;
      assign ctr     = $signed(win_reg[gi][4]);
      assign own_cmp = plane_cmp(ctr, win_reg[gi], 1'b1);
      if (gi > 0) begin : g_lo
        assign lo_cmp = plane_cmp(ctr, win_reg[gi-1], 1'b0);
      end else begin : g_no_lo
        assign lo_cmp = 2'b11;
      end
      if (gi < NUM_DOG - 1) begin : g_hi
        assign hi_cmp = plane_cmp(ctr, win_reg[gi+1], 1'b0);
      end else begin : g_no_hi
        assign hi_cmp = 2'b11;
      end
`ifdef EXTREMA_CONTRAST_EN
      // One extra bit so |most negative sample| is representable.
      logic signed [BIT_DEPTH:0] ctr_ext, ctr_abs;
      assign ctr_ext     = {ctr[BIT_DEPTH-1], ctr};
      assign ctr_abs     = ctr_ext[BIT_DEPTH] ? -ctr_ext : ctr_ext;
      assign contrast_ok = int'(ctr_abs) > ABS_CONTRAST_THRESHOLD;
`else
      assign contrast_ok = 1'b1;
`endif
      assign cand_max[gi] = own_cmp[1] & lo_cmp[1] & hi_cmp[1] & contrast_ok;
      assign cand_min[gi] = own_cmp[0] & lo_cmp[0] & hi_cmp[0] & contrast_ok;
    end
  endgenerate

`ifndef EXTREMA_CONTRAST_EN
  logic unused_threshold;
  assign unused_threshold = ^ABS_CONTRAST_THRESHOLD;
`endif

  assign cand_any = cand_max | cand_min;

  always_comb begin
    // FILL issues slot cnt (row-major); SHIFT issues rows 0..2 of column x+1
    // during cnt 1..3.
    fill_addr  = ADDR_W'((int'(y_reg) - 1 + int'(cnt_reg) / 3) * DIMENSION
                         + int'(x_reg) - 1 + int'(cnt_reg) % 3);
    shift_addr = ADDR_W'((int'(y_reg) - 2 + int'(cnt_reg)) * DIMENSION + int'(x_reg) + 1);
    cap_en   = 1'b0;
    cap_slot = 4'd0;
    if (state_reg == S_FILL && cnt_reg >= CNT_W'(READ_LATENCY)) begin
      cap_en   = 1'b1;
      cap_slot = 4'(int'(cnt_reg) - READ_LATENCY);
    end
    if (state_reg == S_SHIFT && cnt_reg >= CNT_W'(READ_LATENCY + 1)) begin
      cap_en   = 1'b1;
      cap_slot = 4'((int'(cnt_reg) - 1 - READ_LATENCY) * 3 + 2);
    end
  end

  // Lowest flagged scale: from fresh comparison results in COMPARE, or from
  // the flags still outstanding after the current keypoint in EMIT.
  always_comb begin
    pending  = flags_reg & ~(NUM_DOG'(1) << kp_scale_reg);
    pick_src = (state_reg == S_COMPARE) ? cand_any : pending;
    max_src  = (state_reg == S_COMPARE) ? cand_max : max_reg;
    pick_idx = '0;
    pick_max = 1'b0;
    for (int i = NUM_DOG - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        pick_idx = SCALE_W'(i);
        pick_max = max_src[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      for (int s = 0; s < NUM_DOG; s++) win_reg[s] <= '0;
      flags_reg       <= '0;
      max_reg         <= '0;
      dog_address_reg <= '0;
      kp_valid_reg    <= 1'b0;
      kp_x_reg        <= '0;
      kp_y_reg        <= '0;
      kp_scale_reg    <= '0;
      kp_is_max_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (cap_en) begin
        for (int s = 0; s < NUM_DOG; s++)
          win_reg[s][cap_slot] <= bus.dog_data[s*BIT_DEPTH +: BIT_DEPTH];
      end
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            x_reg     <= COORD_W'(1);
            y_reg     <= COORD_W'(1);
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= S_FILL;
          end
        end
        S_FILL: begin
          if (cnt_reg < CNT_W'(9)) dog_address_reg <= fill_addr;
          if (cnt_reg == CNT_W'(8 + READ_LATENCY)) begin
            cnt_reg   <= '0;
            state_reg <= S_COMPARE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (cnt_reg == '0) begin
            for (int s = 0; s < NUM_DOG; s++) begin
              for (int r = 0; r < 3; r++) begin
                win_reg[s][r*3]   <= win_reg[s][r*3+1];
                win_reg[s][r*3+1] <= win_reg[s][r*3+2];
              end
            end
          end
          if (cnt_reg >= CNT_W'(1) && cnt_reg <= CNT_W'(3)) dog_address_reg <= shift_addr;
          if (cnt_reg == CNT_W'(3 + READ_LATENCY)) begin
            cnt_reg   <= '0;
            state_reg <= S_COMPARE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        S_COMPARE: begin
          flags_reg <= cand_any;
          max_reg   <= cand_max;
          if (|cand_any) begin
            kp_valid_reg  <= 1'b1;
            kp_x_reg      <= x_reg;
            kp_y_reg      <= y_reg;
            kp_scale_reg  <= pick_idx;
            kp_is_max_reg <= pick_max;
            state_reg     <= S_EMIT;
          end else begin
            state_reg <= S_ADVANCE;
          end
        end
        S_EMIT: begin
          // kp_valid is always high here; only a handshake moves things on.
          if (bus.kp_ready) begin
            flags_reg <= pending;
            if (|pending) begin
              kp_scale_reg  <= pick_idx;
              kp_is_max_reg <= pick_max;
            end else begin
              kp_valid_reg <= 1'b0;
              state_reg    <= S_ADVANCE;
            end
          end
        end
        S_ADVANCE: begin
          cnt_reg <= '0;
          if (x_reg < COORD_W'(DIMENSION - 2)) begin
            x_reg     <= x_reg + COORD_W'(1);
            state_reg <= S_SHIFT;
          end else if (y_reg < COORD_W'(DIMENSION - 2)) begin
            x_reg     <= COORD_W'(1);
            y_reg     <= y_reg + COORD_W'(1);
            state_reg <= S_FILL;
          end else begin
            // done is visible during FINISH, so a start in that cycle is ignored.
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_FINISH;
          end
        end
        S_FINISH: state_reg <= S_IDLE;
        default:  state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.dog_address = dog_address_reg;
  assign bus.kp_valid    = kp_valid_reg;
  assign bus.kp_x        = kp_x_reg;
  assign bus.kp_y        = kp_y_reg;
  assign bus.kp_scale    = kp_scale_reg;
  assign bus.kp_is_max   = kp_is_max_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
endmodule

// File: tb/tb_extrema_scanner.sv
// tb_extrema_scanner
//   Two scanner instances on 4x4 images (2 and 3 DoG scales, READ_LATENCY 2)
//   fed by behavioural BRAMs. Expected keypoints are queued when a scan is
//   set up; per-instance monitors pop and compare on every handshake.
module tb_extrema_scanner;
  localparam int BD = 9;

  typedef struct {
    int x;
    int y;
    int s;
    int mx;
  } kp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;

  extrema_scanner_if #(.BIT_DEPTH(BD), .DIMENSION(4), .NUM_DOG(2)) bus_a ();
  extrema_scanner_if #(.BIT_DEPTH(BD), .DIMENSION(4), .NUM_DOG(3)) bus_b ();

  extrema_scanner #(.BIT_DEPTH(BD), .DIMENSION(4), .NUM_DOG(2), .READ_LATENCY(2),
                    .ABS_CONTRAST_THRESHOLD(4)) dut_a (
    .clk(clk), .rst_in(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a));

  extrema_scanner #(.BIT_DEPTH(BD), .DIMENSION(4), .NUM_DOG(3), .READ_LATENCY(2),
                    .ABS_CONTRAST_THRESHOLD(4)) dut_b (
    .clk(clk), .rst_in(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b));

  logic signed [BD-1:0] mem_a [2][16];
  logic signed [BD-1:0] mem_b [3][16];

  // Address loaded at the end of cycle k, one BRAM register stage:
  // data is present in cycle k+2.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) bus_a.dog_data[s*BD +: BD] <= mem_a[s][bus_a.dog_address];
    for (int s = 0; s < 3; s++) bus_b.dog_data[s*BD +: BD] <= mem_b[s][bus_b.dog_address];
  end

  int  n_tests = 0;
  int  n_fail = 0;
  int  done_cnt_a = 0;
  int  done_cnt_b = 0;
  kp_t exp_a[$];
  kp_t exp_b[$];

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin : mon_a
    kp_t e;
    if (done_a) done_cnt_a++;
    if (bus_a.kp_valid && bus_a.kp_ready) begin
      if (exp_a.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL kp_a_unexpected: got x=%0d y=%0d scale=%0d is_max=%0d, expected none",
                 bus_a.kp_x, bus_a.kp_y, bus_a.kp_scale, bus_a.kp_is_max);
      end else begin
        e = exp_a.pop_front();
        check("kp_a_x", int'(bus_a.kp_x), e.x);
        check("kp_a_y", int'(bus_a.kp_y), e.y);
        check("kp_a_scale", int'(bus_a.kp_scale), e.s);
        check("kp_a_is_max", int'(bus_a.kp_is_max), e.mx);
        $display("[TB] a: keypoint x=%0d y=%0d scale=%0d is_max=%0d",
                 bus_a.kp_x, bus_a.kp_y, bus_a.kp_scale, bus_a.kp_is_max);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    kp_t e;
    if (done_b) done_cnt_b++;
    if (bus_b.kp_valid && bus_b.kp_ready) begin
      if (exp_b.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL kp_b_unexpected: got x=%0d y=%0d scale=%0d is_max=%0d, expected none",
                 bus_b.kp_x, bus_b.kp_y, bus_b.kp_scale, bus_b.kp_is_max);
      end else begin
        e = exp_b.pop_front();
        check("kp_b_x", int'(bus_b.kp_x), e.x);
        check("kp_b_y", int'(bus_b.kp_y), e.y);
        check("kp_b_scale", int'(bus_b.kp_scale), e.s);
        check("kp_b_is_max", int'(bus_b.kp_is_max), e.mx);
        $display("[TB] b: keypoint x=%0d y=%0d scale=%0d is_max=%0d",
                 bus_b.kp_x, bus_b.kp_y, bus_b.kp_scale, bus_b.kp_is_max);
      end
    end
  end

  task automatic clear_mem();
    for (int s = 0; s < 2; s++) for (int i = 0; i < 16; i++) mem_a[s][i] = '0;
    for (int s = 0; s < 3; s++) for (int i = 0; i < 16; i++) mem_b[s][i] = '0;
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk);
    #1;
    if (which == 0) start_a = 1'b1;
    else            start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int which, input string name, input int base);
    int cyc;
    int got;
    cyc = 0;
    got = (which == 0) ? done_cnt_a : done_cnt_b;
    while (got == base && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      got = (which == 0) ? done_cnt_a : done_cnt_b;
    end
    repeat (5) @(negedge clk);
    got = (which == 0) ? done_cnt_a : done_cnt_b;
    check({name, "_done_pulses"}, got - base, 1);
    check({name, "_kp_outstanding"}, (which == 0) ? exp_a.size() : exp_b.size(), 0);
    $display("[TB] scan %s finished after %0d cycles", name, cyc);
  endtask

  task automatic run_scan(input int which, input string name);
    int base;
    base = (which == 0) ? done_cnt_a : done_cnt_b;
    pulse_start(which);
    wait_done(which, name, base);
  endtask

  task automatic stall_watch();
    int cyc;
    cyc = 0;
    while (!bus_a.kp_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("stall_valid_seen", int'(bus_a.kp_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", int'(bus_a.kp_valid), 1);
      check("stall_x", int'(bus_a.kp_x), 1);
      check("stall_y", int'(bus_a.kp_y), 1);
      check("stall_scale", int'(bus_a.kp_scale), 0);
      check("stall_is_max", int'(bus_a.kp_is_max), 1);
    end
    @(posedge clk);
    #1;
    bus_a.kp_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_addr [4];
    exp_addr = '{0, 1, 2, 4};
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.kp_ready = 1'b1;
    bus_b.kp_ready = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);

    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_kp_valid", int'(bus_a.kp_valid), 0);
    check("rst_address", int'(bus_a.dog_address), 0);
    check("rst_kp_x", int'(bus_a.kp_x), 0);
    check("rst_b_busy", int'(busy_b), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Isolated maximum on scale 0 at (1,1) (address 5).
    clear_mem();
    mem_a[0][5] = 20;
    exp_a.push_back('{1, 1, 0, 1});
    run_scan(0, "single_max");

    // Equal peak on scale 1: the tie disqualifies both.
    mem_a[1][5] = 20;
    run_scan(0, "tie");

    // Three scales, minimum on the middle one at (2,2) (address 10).
    clear_mem();
    mem_b[1][10] = -30;
    exp_b.push_back('{2, 2, 1, 0});
    run_scan(1, "mid_min");

    // Weak peak: only reported without the contrast check.
    clear_mem();
    mem_a[0][5] = 3;
`ifndef EXTREMA_CONTRAST_EN
    exp_a.push_back('{1, 1, 0, 1});
`endif
    run_scan(0, "low_contrast");

    // Two scales flagged at one pixel with the consumer stalled.
    clear_mem();
    mem_a[0][5] = 20;
    mem_a[1][5] = -20;
    exp_a.push_back('{1, 1, 0, 1});
    exp_a.push_back('{1, 1, 1, 0});
    bus_a.kp_ready = 1'b0;
    fork
      run_scan(0, "stall");
      stall_watch();
    join

    // Reset during the FILL of row 2: 26 cycles into the scan.
    clear_mem();
    base = done_cnt_a;
    pulse_start(0);
    repeat (26) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", int'(busy_a), 0);
    check("abort_done", int'(done_a), 0);
    check("abort_kp_valid", int'(bus_a.kp_valid), 0);
    check("abort_address", int'(bus_a.dog_address), 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt_a - base, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fresh scan after the abort starts again at (1,1).
    mem_a[0][5] = 20;
    exp_a.push_back('{1, 1, 0, 1});
    base = done_cnt_a;
    pulse_start(0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rescan_address", int'(bus_a.dog_address), exp_addr[i]);
    end
    check("rescan_busy", int'(busy_a), 1);
    wait_done(0, "rescan", base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
